pc_gen: RTL and testbench

Parametrised fetch-stage program counter for the pipelined MIPS core. It replaces the bare PC register. It selects the next PC from five sources: sequential, branch (EX), jump (ID), exception vector and ERET return. It holds on stall. A redirect that arrives during a stall is captured in a pending register and applied when the stall releases, so no redirect is lost.

---
 rtl/pc_gen_if.sv | 30 +++
 rtl/pc_gen.sv | 107 ++++++++++
 tb/tb_pc_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-stage PC interface: hazard/redirect controls in, fetch address and status out.
// The bench or core-side driver uses master; pc_gen uses slave.
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              pc_write;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              jmp_taken;
    logic [ADDR_W-1:0] jmp_target;
    logic              exc_req;
    logic              eret_req;
    logic [ADDR_W-1:0] epc_in;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus;
    logic              redirect_pending;
    logic              misalign;

    modport master (
        output pc_write, br_taken, br_target, jmp_taken, jmp_target,
               exc_req, eret_req, epc_in,
        input  pc_out, pc_plus, redirect_pending, misalign
    );

    modport slave (
        input  pc_write, br_taken, br_target, jmp_taken, jmp_target,
               exc_req, eret_req, epc_in,
        output pc_out, pc_plus, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter with prioritised redirects, stall hold and a
// pending-redirect register so a redirect seen during a stall is never lost.
module pc_gen #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0180,
    parameter int          INC       = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    pc_gen_if.slave bus
);
    localparam logic [ADDR_W-1:0] RST_T = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_T = ADDR_W'(EXC_VEC);
    localparam logic [ADDR_W-1:0] INC_T = ADDR_W'(INC);

    typedef enum logic {IDLE, HOLD} state_t;
    // Encoding order is the priority order, so class comparison is a plain >=.
    typedef enum logic [1:0] {CLS_JMP = 2'd0, CLS_BR = 2'd1, CLS_ERET = 2'd2, CLS_EXC = 2'd3} cls_t;

    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
        return a + b;
    endfunction

    state_t            state_q, state_d;
    cls_t              hold_cls_q, hold_cls_d;
    logic [ADDR_W-1:0] hold_tgt_q, hold_tgt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus;
    logic              live_vld;
    cls_t              live_cls;
    logic [ADDR_W-1:0] live_tgt;
    logic              take_live;

    assign pc_plus              = wrap_add(pc_q, INC_T);
    assign bus.pc_out           = pc_q;
    assign bus.pc_plus          = pc_plus;
    assign bus.redirect_pending = (state_q == HOLD);
    assign bus.misalign         = |pc_q[1:0];

    always_comb begin
        live_vld = bus.exc_req | bus.eret_req | bus.br_taken | bus.jmp_taken;
        live_cls = CLS_JMP;
        live_tgt = bus.jmp_target;
        if (bus.exc_req) begin
            live_cls = CLS_EXC;
            live_tgt = EXC_T;
        end else if (bus.eret_req) begin
            live_cls = CLS_ERET;
            live_tgt = bus.epc_in;
        end else if (bus.br_taken) begin
            // A branch in EX is older than a jump in ID; the jump is on its wrong path.
            live_cls = CLS_BR;
            live_tgt = bus.br_target;
        end
    end

    assign take_live = live_vld && (live_cls >= hold_cls_q);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_tgt_d = hold_tgt_q;
        hold_cls_d = hold_cls_q;
        if (bus.exc_req) begin
            // Exceptions flush the front end regardless of the stall.
            pc_d       = EXC_T;
            state_d    = IDLE;
            hold_cls_d = CLS_JMP;
        end else if (state_q == IDLE) begin
            if (bus.pc_write) begin
                pc_d = live_vld ? live_tgt : pc_plus;
            end else if (live_vld) begin
                hold_tgt_d = live_tgt;
                hold_cls_d = live_cls;
                state_d    = HOLD;
            end
        end else begin
            if (bus.pc_write) begin
                pc_d       = take_live ? live_tgt : hold_tgt_q;
                state_d    = IDLE;
                hold_cls_d = CLS_JMP;
            end else if (take_live) begin
                hold_tgt_d = live_tgt;
                hold_cls_d = live_cls;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cls_q <= CLS_JMP;
            pc_q       <= RST_T;
        end else begin
            state_q    <= state_d;
            hold_cls_q <= hold_cls_d;
            pc_q       <= pc_d;
        end
    end

    // Held target is only meaningful while state_q == HOLD, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_tgt_q <= hold_tgt_d;
    end
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance for redirect/stall behaviour
// and a 16-bit instance for wrap-around, misalign and reset-during-hold.
module tb_pc_gen;
    logic clk;
    logic rst_n;

    pc_gen_if #(.ADDR_W(32)) bus32 ();
    pc_gen_if #(.ADDR_W(16)) bus16 ();

    pc_gen #(.ADDR_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    pc_gen #(.ADDR_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          pw, exc, eret, br, jmp;
        logic [31:0] brt, jmpt, epc;
        logic [31:0] exp_pc;
        bit          exp_pend;
    } step_t;

    typedef struct {
        logic [31:0] pc;
        bit          pend;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic step_t mk(bit pw, bit exc, bit eret, bit br, logic [31:0] brt,
                                 bit jmp, logic [31:0] jmpt, logic [31:0] epc,
                                 logic [31:0] exp_pc, bit exp_pend);
        step_t s;
        s.pw = pw; s.exc = exc; s.eret = eret; s.br = br; s.jmp = jmp;
        s.brt = brt; s.jmpt = jmpt; s.epc = epc;
        s.exp_pc = exp_pc; s.exp_pend = exp_pend;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input step_t s);
        bus32.pc_write = s.pw; bus32.exc_req = s.exc; bus32.eret_req = s.eret;
        bus32.br_taken = s.br; bus32.br_target = s.brt;
        bus32.jmp_taken = s.jmp; bus32.jmp_target = s.jmpt; bus32.epc_in = s.epc;
    endtask

    task automatic drive16(input step_t s);
        bus16.pc_write = s.pw; bus16.exc_req = s.exc; bus16.eret_req = s.eret;
        bus16.br_taken = s.br; bus16.br_target = s.brt[15:0];
        bus16.jmp_taken = s.jmp; bus16.jmp_target = s.jmpt[15:0]; bus16.epc_in = s.epc[15:0];
    endtask

    task automatic run32(input string name, input step_t s[$]);
        exp_t e;
        foreach (s[i]) begin
            drive32(s[i]);
            sb_q.push_back('{pc: s[i].exp_pc, pend: s[i].exp_pend});
            tick();
            e = sb_q.pop_front();
            vectors++;
            if (bus32.pc_out !== e.pc) begin
                miscompares++;
                $display("FAIL %s[%0d] pc_out got %h want %h", name, i, bus32.pc_out, e.pc);
            end
            vectors++;
            if (bus32.redirect_pending !== e.pend) begin
                miscompares++;
                $display("FAIL %s[%0d] redirect_pending got %b want %b", name, i, bus32.redirect_pending, e.pend);
            end
            vectors++;
            if (bus32.pc_plus !== e.pc + 32'd4) begin
                miscompares++;
                $display("FAIL %s[%0d] pc_plus got %h want %h", name, i, bus32.pc_plus, e.pc + 32'd4);
            end
            vectors++;
            if (bus32.misalign !== (e.pc[1:0] != 2'b00)) begin
                miscompares++;
                $display("FAIL %s[%0d] misalign got %b want %b", name, i, bus32.misalign, e.pc[1:0] != 2'b00);
            end
        end
        drive32(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_reset();
        step_t s[$];
        rst_n = 1'b0;
        drive32(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive16(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        vectors++;
        if (bus32.pc_out !== 32'h0 || bus32.redirect_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL reset pc_out/pending got %h/%b want 00000000/0", bus32.pc_out, bus32.redirect_pending);
        end
        vectors++;
        if (bus32.pc_plus !== 32'h4) begin
            miscompares++;
            $display("FAIL reset pc_plus got %h want 00000004", bus32.pc_plus);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'(4 * i), 0));
        run32("seq", s);
    endtask

    task automatic test_stall();
        step_t s[$];
        s.push_back(mk(1, 0, 0, 0, 0, 1, 32'h100, 0, 32'h100, 0));
        for (int i = 0; i < 4; i++) s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0));
        run32("stall", s);
    endtask

    task automatic test_priority();
        step_t s[$];
        s.push_back(mk(1, 0, 0, 0, 0, 1, 32'h200, 0, 32'h200, 0));
        s.push_back(mk(1, 0, 0, 1, 32'h400, 1, 32'h800, 0, 32'h400, 0));
        s.push_back(mk(1, 0, 1, 1, 32'h700, 0, 0, 32'h500, 32'h500, 0));
        s.push_back(mk(1, 0, 0, 1, 32'h400, 0, 0, 0, 32'h400, 0));
        run32("prio", s);
    endtask

    task automatic test_hold();
        step_t s[$];
        s.push_back(mk(0, 0, 0, 0, 0, 1, 32'h800, 0, 32'h400, 1));
        s.push_back(mk(0, 0, 0, 1, 32'h600, 0, 0, 0, 32'h400, 1));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 32'h900, 0, 32'h400, 1));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h600, 0));
        // Release with a live redirect: lower class loses, higher class wins.
        s.push_back(mk(0, 0, 0, 1, 32'h700, 0, 0, 0, 32'h600, 1));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 32'hA00, 0, 32'h700, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB00, 0, 32'h700, 1));
        s.push_back(mk(1, 0, 0, 1, 32'hC00, 0, 0, 0, 32'hC00, 0));
        run32("hold", s);
    endtask

    task automatic test_exc();
        step_t s[$];
        s.push_back(mk(0, 0, 0, 1, 32'h600, 0, 0, 0, 32'hC00, 1));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h8000_0180, 0));
        s.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h604, 32'h604, 0));
        s.push_back(mk(0, 1, 0, 1, 32'h10, 0, 0, 0, 32'h8000_0180, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0184, 0));
        run32("exc", s);
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        s.push_back(mk(1, 0, 0, 0, 0, 1, 32'h1000, 0, 32'h1000, 0));
        s.push_back(mk(1, 0, 0, 1, 32'h2000, 0, 0, 0, 32'h2000, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h2004, 0));
        s.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h3000, 32'h3000, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 32'h1002, 0, 32'h1002, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h1006, 0));
        run32("b2b", s);
    endtask

    task automatic test_wrap16();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 32'hFFFC, 0, 32'hFFFC, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0102, 0, 32'h0102, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0300, 0, 32'h0102, 1));
        foreach (s[i]) begin
            drive16(s[i]);
            sb_q.push_back('{pc: s[i].exp_pc, pend: s[i].exp_pend});
            tick();
            e = sb_q.pop_front();
            vectors++;
            if (bus16.pc_out !== e.pc[15:0] || bus16.redirect_pending !== e.pend) begin
                miscompares++;
                $display("FAIL wrap16[%0d] pc_out/pending got %h/%b want %h/%b",
                         i, bus16.pc_out, bus16.redirect_pending, e.pc[15:0], e.pend);
            end
            vectors++;
            if (bus16.pc_plus !== 16'(e.pc + 32'd4)) begin
                miscompares++;
                $display("FAIL wrap16[%0d] pc_plus got %h want %h", i, bus16.pc_plus, 16'(e.pc + 32'd4));
            end
            vectors++;
            if (bus16.misalign !== (e.pc[1:0] != 2'b00)) begin
                miscompares++;
                $display("FAIL wrap16[%0d] misalign got %b want %b", i, bus16.misalign, e.pc[1:0] != 2'b00);
            end
        end
    endtask

    task automatic test_reset_in_hold();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus16.pc_out !== 16'h0 || bus16.redirect_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_hold async pc_out/pending got %h/%b want 0000/0", bus16.pc_out, bus16.redirect_pending);
        end
        tick();
        rst_n = 1'b1;
        drive16(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb_q.push_back('{pc: 32'h4, pend: 1'b0});
        tick();
        begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            if (bus16.pc_out !== e.pc[15:0] || bus16.redirect_pending !== e.pend) begin
                miscompares++;
                $display("FAIL rst_hold discard pc_out/pending got %h/%b want %h/%b",
                         bus16.pc_out, bus16.redirect_pending, e.pc[15:0], e.pend);
            end
        end
        drive16(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        test_reset();
        test_stall();
        test_priority();
        test_hold();
        test_exc();
        test_back_to_back();
        test_wrap16();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
